// File: rtl/set_mode_ctrl_if.sv
// Button/strobe bundle between the debouncer, the set-mode controller and the
// timekeeping/alarm blocks. Bit map: 0 MODE, 1 SEL, 2 UP, 3 DOWN, 4 OK.
`timescale 1ns/1ps
`default_nettype none

interface set_mode_ctrl_if #(
   parameter int BTN_WIDTH = 5
);
   logic [BTN_WIDTH-1:0] btn_level;
   logic [BTN_WIDTH-1:0] btn_pulse;
   logic [1:0]           mode;
   logic [1:0]           field_sel;
   logic                 inc;
   logic                 dec;
   logic                 blink_en;
   logic                 save_time;
   logic                 save_alarm;

   modport master (
      output btn_level, btn_pulse,
      input  mode, field_sel, inc, dec, blink_en, save_time, save_alarm
   );

   modport slave (
      input  btn_level, btn_pulse,
      output mode, field_sel, inc, dec, blink_en, save_time, save_alarm
   );
endinterface

`default_nettype wire

// File: rtl/set_mode_ctrl.sv
// Clock-setting UI controller: RUN/SET_TIME/SET_ALARM sequencing, field select,
// inc/dec with long-press auto-repeat, save strobes. Optional: SETMODE_TIMEOUT_EN.
`timescale 1ns/1ps
`default_nettype none

module set_mode_ctrl #(
   parameter int BTN_WIDTH      = 5,
   parameter int CNT_W          = 32,
   parameter int HOLD_CYCLES    = 6000000,
   parameter int REPEAT_CYCLES  = 1200000,
   parameter int TIMEOUT_CYCLES = 60000000
) (
   input  logic          clk,
   input  logic          rst,
   set_mode_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      MODE_RUN       = 2'd0,
      MODE_SET_TIME  = 2'd1,
      MODE_SET_ALARM = 2'd2
   } mode_e;

   typedef enum logic {
      PH_FIRST  = 1'b0,
      PH_REPEAT = 1'b1
   } phase_e;

   localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ?
      ((HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES) :
      ((REPEAT_CYCLES > TIMEOUT_CYCLES) ? REPEAT_CYCLES : TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] L_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] L_REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   if (BTN_WIDTH != 5 || CNT_W <= $clog2(MAX_CYC)) begin : g_param_check
      $error("set_mode_ctrl: BTN_WIDTH must be 5 and CNT_W must hold the largest cycle count");
   end

   logic w_p_mode, w_p_sel, w_p_up, w_p_dn, w_p_ok, w_lv_up, w_lv_dn;
   assign w_p_mode = bus.btn_pulse[0];
   assign w_p_sel  = bus.btn_pulse[1];
   assign w_p_up   = bus.btn_pulse[2];
   assign w_p_dn   = bus.btn_pulse[3];
   assign w_p_ok   = bus.btn_pulse[4];
   assign w_lv_up  = bus.btn_level[2];
   assign w_lv_dn  = bus.btn_level[3];

   // MODE/SEL/OK act on pulses only; their levels are deliberately ignored.
   logic w_unused;
   assign w_unused = ^{bus.btn_level[4], bus.btn_level[1:0]};

   mode_e            r_mode, w_mode;
   phase_e           r_phase, w_phase;
   logic [1:0]       r_field, w_field;
   logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt;
   logic             r_armed, w_armed, r_dir_up, w_dir_up;
   logic             r_inc, w_inc, r_dec, w_dec, r_blink, w_blink;
   logic             r_save_time, w_save_time, r_save_alarm, w_save_alarm;
   logic             w_mode_chg;
`ifdef SETMODE_TIMEOUT_EN
   localparam logic [CNT_W-1:0] L_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] r_to_cnt, w_to_cnt;
`endif

   // NOTE: every variable gets a default before any branch so the block cannot infer a latch.
   always_comb begin
      w_mode       = r_mode;
      w_field      = r_field;
      w_phase      = r_phase;
      w_hold_cnt   = r_hold_cnt;
      w_armed      = r_armed;
      w_dir_up     = r_dir_up;
      w_inc        = 1'b0;
      w_dec        = 1'b0;
      w_save_time  = 1'b0;
      w_save_alarm = 1'b0;
      w_mode_chg   = 1'b0;
`ifdef SETMODE_TIMEOUT_EN
      w_to_cnt     = '0;
`endif
      if (w_p_mode) begin
         w_mode_chg = 1'b1;
         case (r_mode)
            MODE_RUN:      w_mode = MODE_SET_TIME;
            MODE_SET_TIME: w_mode = MODE_SET_ALARM;
            default:       w_mode = MODE_RUN;
         endcase
      end else if (w_p_ok && r_mode != MODE_RUN) begin
         w_mode_chg   = 1'b1;
         w_save_time  = (r_mode == MODE_SET_TIME);
         w_save_alarm = (r_mode == MODE_SET_ALARM);
         w_mode       = MODE_RUN;
      end else if (r_mode != MODE_RUN) begin
         if (w_p_sel) begin
            if (r_mode == MODE_SET_TIME) w_field = (r_field == 2'd2) ? 2'd0 : r_field + 2'd1;
            else                         w_field = (r_field == 2'd0) ? 2'd1 : 2'd0;
         end
         // A held key only repeats after a pulse armed it, so a key held across reset stays inert.
         if ((w_lv_up && w_lv_dn) || (w_p_up && w_p_dn)) begin
            w_hold_cnt = '0;
            w_phase    = PH_FIRST;
         end else if (!w_p_sel && (w_p_up || w_p_dn)) begin
            w_inc      = w_p_up;
            w_dec      = w_p_dn;
            w_hold_cnt = '0;
            w_phase    = PH_FIRST;
            w_armed    = 1'b1;
            w_dir_up   = w_p_up;
         end else if (r_armed && (r_dir_up ? w_lv_up : w_lv_dn)) begin
            if (r_hold_cnt == ((r_phase == PH_FIRST) ? L_HOLD_LAST : L_REP_LAST)) begin
               w_inc      = r_dir_up;
               w_dec      = !r_dir_up;
               w_hold_cnt = '0;
               w_phase    = PH_REPEAT;
            end else begin
               w_hold_cnt = r_hold_cnt + 1'b1;
            end
         end else begin
            w_hold_cnt = '0;
            w_phase    = PH_FIRST;
            w_armed    = 1'b0;
         end
`ifdef SETMODE_TIMEOUT_EN
         if ((|bus.btn_pulse) || w_lv_up || w_lv_dn) begin
            w_to_cnt = '0;
         end else if (r_to_cnt == L_TO_LAST) begin
            w_mode     = MODE_RUN;
            w_mode_chg = 1'b1;
         end else begin
            w_to_cnt = r_to_cnt + 1'b1;
         end
`else
         // Without the timeout, a set mode is left only by MODE or OK.
`endif
      end
      if (w_mode_chg) begin
         w_field    = 2'd0;
         w_hold_cnt = '0;
         w_phase    = PH_FIRST;
         w_armed    = 1'b0;
      end
      w_blink = (w_mode != MODE_RUN);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mode       <= MODE_RUN;
         r_field      <= 2'd0;
         r_phase      <= PH_FIRST;
         r_hold_cnt   <= '0;
         r_armed      <= 1'b0;
         r_dir_up     <= 1'b0;
         r_inc        <= 1'b0;
         r_dec        <= 1'b0;
         r_blink      <= 1'b0;
         r_save_time  <= 1'b0;
         r_save_alarm <= 1'b0;
`ifdef SETMODE_TIMEOUT_EN
         r_to_cnt     <= '0;
`endif
      end else begin
         r_mode       <= w_mode;
         r_field      <= w_field;
         r_phase      <= w_phase;
         r_hold_cnt   <= w_hold_cnt;
         r_armed      <= w_armed;
         r_dir_up     <= w_dir_up;
         r_inc        <= w_inc;
         r_dec        <= w_dec;
         r_blink      <= w_blink;
         r_save_time  <= w_save_time;
         r_save_alarm <= w_save_alarm;
`ifdef SETMODE_TIMEOUT_EN
         r_to_cnt     <= w_to_cnt;
`endif
      end
   end

   assign bus.mode       = r_mode;
   assign bus.field_sel  = r_field;
   assign bus.inc        = r_inc;
   assign bus.dec        = r_dec;
   assign bus.blink_en   = r_blink;
   assign bus.save_time  = r_save_time;
   assign bus.save_alarm = r_save_alarm;

endmodule

`default_nettype wire

// File: tb/tb_set_mode_ctrl.sv
// Directed bench for set_mode_ctrl: vector table for single-cycle behaviour plus
// sequences for auto-repeat, reset mid-press and the inactivity timeout.
`timescale 1ns/1ps

module tb_set_mode_ctrl;
   localparam int HOLD = 8;
   localparam int REP  = 4;
   localparam int TO   = 32;
`ifdef SETMODE_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   localparam logic [4:0] B_NONE = 5'h00;
   localparam logic [4:0] B_MODE = 5'h01;
   localparam logic [4:0] B_SEL  = 5'h02;
   localparam logic [4:0] B_UP   = 5'h04;
   localparam logic [4:0] B_DN   = 5'h08;
   localparam logic [4:0] B_OK   = 5'h10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   set_mode_ctrl_if #(.BTN_WIDTH(5)) bus ();

   set_mode_ctrl #(
      .BTN_WIDTH(5), .CNT_W(32), .HOLD_CYCLES(HOLD),
      .REPEAT_CYCLES(REP), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [4:0] lvl;
      logic [4:0] pls;
      logic [1:0] mode;
      logic [1:0] field;
      logic       inc;
      logic       dec;
      logic       st;
      logic       sa;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Output bundle {mode, field_sel, inc, dec, save_time, save_alarm, blink_en}.
   function automatic logic [8:0] pack_exp(input logic [1:0] m, input logic [1:0] f,
                                           input logic i, input logic d,
                                           input logic st, input logic sa);
      return {m, f, i, d, st, sa, (m != 2'd0)};
   endfunction

   function automatic logic [8:0] pack_dut();
      return {bus.mode, bus.field_sel, bus.inc, bus.dec,
              bus.save_time, bus.save_alarm, bus.blink_en};
   endfunction

   task automatic step(input logic [4:0] lvl, input logic [4:0] pls);
      bus.btn_level = lvl;
      bus.btn_pulse = pls;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [4:0] lvl);
      rst           = 1'b1;
      bus.btn_level = lvl;
      bus.btn_pulse = B_NONE;
      repeat (2) @(posedge clk);
      #1;
      check("in_reset", 32'(pack_dut()), 32'(9'h000));
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   function automatic void v(input logic [4:0] lvl, input logic [4:0] pls,
                             input logic [1:0] m, input logic [1:0] f,
                             input logic i, input logic d, input logic st, input logic sa);
      vec_t r;
      r.lvl = lvl; r.pls = pls; r.mode = m; r.field = f;
      r.inc = i; r.dec = d; r.st = st; r.sa = sa;
      vecs.push_back(r);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //  lvl             pulse            mode f  inc dec st sa
      v(B_NONE,          B_NONE,          0, 0, 0, 0, 0, 0);
      v(B_MODE,          B_MODE,          1, 0, 0, 0, 0, 0);
      v(B_NONE,          B_NONE,          1, 0, 0, 0, 0, 0);
      v(B_MODE,          B_MODE,          2, 0, 0, 0, 0, 0);
      v(B_MODE,          B_MODE,          0, 0, 0, 0, 0, 0);
      v(B_OK,            B_OK,            0, 0, 0, 0, 0, 0);  // OK ignored in RUN
      v(B_SEL,           B_SEL,           0, 0, 0, 0, 0, 0);
      v(B_UP,            B_UP,            0, 0, 0, 0, 0, 0);
      v(B_MODE,          B_MODE,          1, 0, 0, 0, 0, 0);
      v(B_SEL,           B_SEL,           1, 1, 0, 0, 0, 0);
      v(B_SEL,           B_SEL,           1, 2, 0, 0, 0, 0);
      v(B_DN,            B_DN,            1, 2, 0, 1, 0, 0);
      v(B_SEL,           B_SEL,           1, 0, 0, 0, 0, 0);  // seconds wrap to hours
      v(B_MODE,          B_MODE,          2, 0, 0, 0, 0, 0);
      v(B_SEL,           B_SEL,           2, 1, 0, 0, 0, 0);
      v(B_SEL,           B_SEL,           2, 0, 0, 0, 0, 0);  // alarm never selects seconds
      v(B_SEL,           B_SEL,           2, 1, 0, 0, 0, 0);
      v(B_MODE,          B_MODE,          0, 0, 0, 0, 0, 0);
      v(B_MODE,          B_MODE,          1, 0, 0, 0, 0, 0);
      v(B_MODE | B_UP,   B_MODE | B_UP,   2, 0, 0, 0, 0, 0);  // MODE beats UP
      v(B_UP,            B_NONE,          2, 0, 0, 0, 0, 0);
      v(B_UP,            B_UP,            2, 0, 1, 0, 0, 0);
      v(B_NONE,          B_NONE,          2, 0, 0, 0, 0, 0);
      v(B_UP | B_DN,     B_UP | B_DN,     2, 0, 0, 0, 0, 0);
      v(B_NONE,          B_NONE,          2, 0, 0, 0, 0, 0);
      v(B_SEL | B_UP,    B_SEL | B_UP,    2, 1, 0, 0, 0, 0);  // SEL beats UP
      v(B_NONE,          B_NONE,          2, 1, 0, 0, 0, 0);
      v(B_OK,            B_OK,            0, 0, 0, 0, 0, 1);
      v(B_NONE,          B_NONE,          0, 0, 0, 0, 0, 0);
      v(B_MODE,          B_MODE,          1, 0, 0, 0, 0, 0);
      v(B_SEL,           B_SEL,           1, 1, 0, 0, 0, 0);
      v(B_OK|B_SEL|B_UP, B_OK|B_SEL|B_UP, 0, 0, 0, 0, 1, 0);  // OK beats SEL/UP
      v(B_NONE,          B_NONE,          0, 0, 0, 0, 0, 0);
      v(B_MODE,          B_MODE,          1, 0, 0, 0, 0, 0);
      v(B_MODE,          B_MODE,          2, 0, 0, 0, 0, 0);
      v(B_UP,            B_UP,            2, 0, 1, 0, 0, 0);
      v(B_MODE,          B_MODE,          0, 0, 0, 0, 0, 0);  // discard, no save
      v(B_NONE,          B_NONE,          0, 0, 0, 0, 0, 0);
      v(B_MODE,          B_MODE,          1, 0, 0, 0, 0, 0);
      v(B_MODE,          B_MODE,          2, 0, 0, 0, 0, 0);
      v(B_OK | B_MODE,   B_OK | B_MODE,   0, 0, 0, 0, 0, 0);  // MODE beats OK
      v(B_NONE,          B_NONE,          0, 0, 0, 0, 0, 0);

      // Reset state and the MODE cycle at fixed cycles.
      do_reset(B_NONE);
      check("reset_state", 32'(pack_dut()), 32'(pack_exp(0, 0, 0, 0, 0, 0)));
      for (int c = 1; c <= 35; c++) begin
         logic [1:0] m;
         step((c == 10 || c == 20 || c == 30) ? B_MODE : B_NONE,
              (c == 10 || c == 20 || c == 30) ? B_MODE : B_NONE);
         m = (c >= 30) ? 2'd0 : (c >= 20) ? 2'd2 : (c >= 10) ? 2'd1 : 2'd0;
         check($sformatf("mode_seq c%0d", c), 32'(pack_dut()), 32'(pack_exp(m, 0, 0, 0, 0, 0)));
      end

      // Table of single-cycle behaviours, applied from reset.
      do_reset(B_NONE);
      foreach (vecs[i]) begin
         step(vecs[i].lvl, vecs[i].pls);
         check($sformatf("vec%0d", i), 32'(pack_dut()),
               32'(pack_exp(vecs[i].mode, vecs[i].field, vecs[i].inc,
                            vecs[i].dec, vecs[i].st, vecs[i].sa)));
      end

      // Auto-repeat: pulse at k=0, key held through k=24, strobes at k=0,8,12,16,20,24.
      do_reset(B_NONE);
      step(B_MODE, B_MODE);
      check("rep_enter", 32'(bus.mode), 32'd1);
      for (int dir = 0; dir < 2; dir++) begin
         logic [4:0] key;
         key = (dir == 0) ? B_UP : B_DN;
         for (int k = 0; k <= 34; k++) begin
            logic hit;
            step((k <= 24) ? key : B_NONE, (k == 0) ? key : B_NONE);
            hit = (k == 0 || k == 8 || k == 12 || k == 16 || k == 20 || k == 24);
            check($sformatf("repeat d%0d k%0d", dir, k), 32'({bus.inc, bus.dec}),
                  32'((dir == 0) ? {hit, 1'b0} : {1'b0, hit}));
         end
      end

      // Both UP and DOWN levels held: no strobes.
      step(B_UP, B_UP);
      check("both_arm_inc", 32'({bus.inc, bus.dec}), 32'(2'b10));
      for (int k = 0; k < 20; k++) begin
         step(B_UP | B_DN, B_NONE);
         check($sformatf("both_held k%0d", k), 32'({bus.inc, bus.dec}), 32'(2'b00));
      end

      // Reset mid-press: UP still held afterwards must not repeat without a new pulse.
      do_reset(B_NONE);
      step(B_MODE, B_MODE);
      step(B_UP, B_UP);
      check("mid_press_inc", 32'(bus.inc), 32'd1);
      repeat (3) step(B_UP, B_NONE);
      do_reset(B_UP);
      check("after_rst_mode", 32'(bus.mode), 32'd0);
      step(B_UP | B_MODE, B_MODE);
      check("after_rst_set", 32'(bus.mode), 32'd1);
      for (int k = 0; k < 12; k++) begin
         step(B_UP, B_NONE);
         check($sformatf("held_after_rst k%0d", k), 32'({bus.inc, bus.dec}), 32'(2'b00));
      end

      // Inactivity in SET_TIME: RUN after 32 idle cycles only when the timeout is built in.
      do_reset(B_NONE);
      step(B_MODE, B_MODE);
      for (int i = 1; i <= 40; i++) begin
         logic [1:0] m;
         step(B_NONE, B_NONE);
         m = (TO_EN && i >= TO) ? 2'd0 : 2'd1;
         check($sformatf("idle i%0d", i), 32'(pack_dut()), 32'(pack_exp(m, 0, 0, 0, 0, 0)));
      end

      // SEL at idle cycle 30 restarts the inactivity count.
      do_reset(B_NONE);
      step(B_MODE, B_MODE);
      for (int i = 1; i <= 70; i++) begin
         logic       to_hit;
         logic [1:0] m, f;
         step((i == 30) ? B_SEL : B_NONE, (i == 30) ? B_SEL : B_NONE);
         to_hit = TO_EN && (i >= 30 + TO);
         m = to_hit ? 2'd0 : 2'd1;
         f = (!to_hit && i >= 30) ? 2'd1 : 2'd0;
         check($sformatf("idle_sel i%0d", i), 32'(pack_dut()), 32'(pack_exp(m, f, 0, 0, 0, 0)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
